core_memory_responder: RTL

Memory-side end of the execute stage's load/store request interface. Accepts one word-aligned request per instruction (enable, write enable, byte select, address, write data) and runs it as a Wishbone-classic master transaction. Returns load data shifted and sign- or zero-extended for writeback, plus completion and fault flags. Sits between the operation pipe stage and the core's data bus port.

---
 rtl/core_memory_pkg.sv | 28 ++
 rtl/load_data_aligner.sv | 27 ++
 rtl/core_memory_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/core_memory_pkg.sv
// Shared types and constants for the core memory responder: load funct3 codes,
// FSM state encoding, timeout counter width and the latched request record.
package core_memory_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } memState_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  funct3;
    logic [1:0]  offset;
  } memReq_t;

endpackage

// File: rtl/load_data_aligner.sv
// Combinational load formatter: picks the byte/halfword lane selected by the
// original address offset and sign- or zero-extends it according to funct3.
module load_data_aligner
  import core_memory_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOffset,
  input  logic [31:0] rawWord,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  always_comb begin
    // Lane `offset` lands in bits [7:0]; halfword takes lanes offset and offset+1.
    shifted = rawWord >> {byteOffset, 3'b000};
    case (funct3)
      F3_LB:   loadData = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   loadData = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   loadData = rawWord;
      F3_LBU:  loadData = {24'd0, shifted[7:0]};
      F3_LHU:  loadData = {16'd0, shifted[15:0]};
      default: loadData = 32'd0;
    endcase
  end

endmodule

// File: rtl/core_memory_responder.sv
// Load/store request to Wishbone-classic master bridge with formatted load return.
// Optional bus timeout enabled by defining CORE_MEMORY_RESPONDER_TIMEOUT_EN.
module core_memory_responder
  import core_memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memoryEnable,
  input  logic        memoryWriteEnable,
  input  logic [3:0]  memoryByteSelect,
  input  logic [31:0] memoryAddress,
  input  logic [31:0] memoryWriteData,
  input  logic [2:0]  loadFunct3,
  input  logic [1:0]  loadByteOffset,
  output logic        memoryBusy,
  output logic        memoryDone,
  output logic        loadDataValid,
  output logic [31:0] loadData,
  output logic        accessFault,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  memState_e   state, stateNext;
  memReq_t     req;
  logic        faultQ;
  logic [31:0] loadDataQ;
  logic [31:0] alignedData;
  logic        accept;
  logic        timeoutHit;
  logic        finishBus;

  assign accept    = memoryEnable && (state != BUS);
  assign finishBus = (state == BUS) && (wb_ack_i || wb_err_i || timeoutHit);

`ifdef CORE_MEMORY_RESPONDER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] toCnt;

  // An ack or err arriving on the last counted cycle takes priority over the timeout.
  assign timeoutHit = (state == BUS) && !wb_ack_i && !wb_err_i &&
                      (toCnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != BUS) toCnt <= '0;
    else                     toCnt <= toCnt + 1'b1;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (memoryEnable) stateNext = BUS;
      BUS:     if (finishBus) stateNext = DONE;
      DONE:    stateNext = memoryEnable ? BUS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o      = (state == BUS);
    wb_stb_o      = (state == BUS);
    wb_we_o       = (state == BUS) && req.we;
    wb_sel_o      = (state == BUS) ? req.sel : 4'd0;
    wb_adr_o      = (state == BUS) ? req.adr : 32'd0;
    wb_dat_o      = (state == BUS) ? req.dat : 32'd0;
    memoryBusy    = (state == BUS);
    memoryDone    = (state == DONE);
    accessFault   = (state == DONE) && faultQ;
    loadDataValid = (state == DONE) && !faultQ && !req.we;
    loadData      = loadDataQ;
  end

  load_data_aligner uAligner (
    .funct3     (req.funct3),
    .byteOffset (req.offset),
    .rawWord    (wb_dat_i),
    .loadData   (alignedData)
  );

  // Result is captured on the BUS->DONE edge so a request accepted during DONE
  // can overwrite the request latch without disturbing the presented result.
  always_ff @(posedge clk) begin
    if (rst) begin
      req       <= '0;
      faultQ    <= 1'b0;
      loadDataQ <= 32'd0;
    end else begin
      if (accept)
        req <= '{we: memoryWriteEnable, sel: memoryByteSelect, adr: memoryAddress,
                 dat: memoryWriteData, funct3: loadFunct3, offset: loadByteOffset};
      if (finishBus) begin
        faultQ    <= wb_err_i || timeoutHit;
        loadDataQ <= (wb_err_i || timeoutHit || req.we) ? 32'd0 : alignedData;
      end
    end
  end

endmodule
